start_cloud_hps_system_button_pio: RTL and testbench



---
 rtl/start_cloud_hps_system_pio_pkg.sv | 30 +++
 rtl/start_cloud_hps_system_debounce_bit.sv | 47 ++++
 rtl/start_cloud_hps_system_button_pio.sv | 87 ++++++++
 tb/tb_start_cloud_hps_system_button_pio.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/start_cloud_hps_system_pio_pkg.sv
// Shared register map and edge-type encodings for the HPS-side PIO blocks.
// The input and output PIO drivers both depend on these constants.
package start_cloud_hps_system_pio_pkg;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_IRQMASK = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Decoded register writes for one bus cycle
  typedef struct packed {
    logic        irqmask;
    logic        edgecap;
    logic [31:0] data;
  } reg_wr_t;

  function automatic logic [31:0] edge_select(input int edge_type,
                                              input logic [31:0] rise,
                                              input logic [31:0] fall);
    case (edge_type)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/start_cloud_hps_system_debounce_bit.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
// deb only follows sync after DEBOUNCE_CYCLES consecutive mismatching cycles.
module start_cloud_hps_system_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic deb
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = din;
    sync_d = meta_q;
    deb_d  = deb_q;
    cnt_d  = '0;
    if (sync_q != deb_q) begin
      if (cnt_q == CNT_LAST) deb_d = sync_q;
      else                   cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign deb = deb_q;

endmodule

// File: rtl/start_cloud_hps_system_button_pio.sv
// Avalon-MM input PIO for the push-buttons: debounced DATA, IRQMASK and
// write-1-to-clear EDGECAP registers with a level interrupt toward the HPS.
module start_cloud_hps_system_button_pio
  import start_cloud_hps_system_pio_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] deb;
  logic [WIDTH-1:0] deb_d_q, deb_d_d;
  logic [WIDTH-1:0] irqmask_q, irqmask_d;
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] rise, fall, edge_set, clr;
  reg_wr_t          wr;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    start_cloud_hps_system_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (in_port[g]),
      .deb  (deb[g])
    );
  end

  if (WIDTH < 32) begin : g_hi
    logic unused_writedata_hi;
    assign unused_writedata_hi = ^writedata[31:WIDTH];
  end

  always_comb begin
    wr.irqmask = chipselect && !write_n && (address == ADDR_IRQMASK);
    wr.edgecap = chipselect && !write_n && (address == ADDR_EDGECAP);
    wr.data    = writedata;

    rise     = deb & ~deb_d_q;
    fall     = ~deb & deb_d_q;
    edge_set = WIDTH'(edge_select(EDGE_TYPE, 32'(rise), 32'(fall)));
    deb_d_d  = deb;

    irqmask_d = irqmask_q;
    if (wr.irqmask) irqmask_d = wr.data[WIDTH-1:0];

    // A new edge in the same cycle as its write-clear must survive
    clr = '0;
    if (wr.edgecap) clr = wr.data[WIDTH-1:0];
    edgecap_d = (edgecap_q & ~clr) | edge_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      deb_d_q   <= '0;
      irqmask_q <= '0;
      edgecap_q <= '0;
    end else begin
      deb_d_q   <= deb_d_d;
      irqmask_q <= irqmask_d;
      edgecap_q <= edgecap_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:    readdata[WIDTH-1:0] = deb;
      ADDR_IRQMASK: readdata[WIDTH-1:0] = irqmask_q;
      ADDR_EDGECAP: readdata[WIDTH-1:0] = edgecap_q;
      default:      readdata = '0;
    endcase
  end

  assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_start_cloud_hps_system_button_pio.sv
// Directed bench for the button PIO (WIDTH=4, DEBOUNCE_CYCLES=4, falling edges).
// Expected values are queued as stimulus is applied and popped at each sample point.
module tb_start_cloud_hps_system_button_pio;

  localparam int W  = 4;
  localparam int DC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  in_port = '1;
  logic          irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  start_cloud_hps_system_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #10 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string tag, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic compare(input logic [31:0] obs);
    exp_t x;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: observed %h, nothing expected", obs);
    end else begin
      x = sb.pop_front();
      assert (obs === x.exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic chk_rd(input string tag, input logic [1:0] a, input logic [3:0] e);
    expect_v(tag, 32'(e));
    address = a;
    #1;
    compare(readdata);
  endtask

  task automatic chk_irq(input string tag, input logic e);
    expect_v(tag, 32'(e));
    #1;
    compare(32'(irq));
  endtask

  task automatic chk_all(input string tag, input logic [3:0] d, input logic [3:0] m,
                         input logic [3:0] c, input logic i);
    chk_rd({tag, "_data"}, 2'd0, d);
    chk_rd({tag, "_mask"}, 2'd1, m);
    chk_rd({tag, "_ecap"}, 2'd3, c);
    chk_irq({tag, "_irq"}, i);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with keys idle high
    in_port = 4'hF;
    reset   = 1'b1;
    tick(3);
    chk_all("rst", 4'h0, 4'h0, 4'h0, 1'b0);
    chk_rd("rst_a2", 2'd2, 4'h0);
    reset = 1'b0;
    tick(5);
    chk_rd("rst_data_e5", 2'd0, 4'h0);
    tick(1);
    chk_rd("rst_data_e6", 2'd0, 4'hF);
    tick(4);
    chk_all("rst_idle", 4'hF, 4'h0, 4'h0, 1'b0);

    // Press bit 0 with it unmasked
    wr(2'd1, 32'h1);
    chk_rd("press_mask", 2'd1, 4'h1);
    in_port = 4'hE;
    tick(5);
    chk_rd("press_e5", 2'd0, 4'hF);
    tick(1);
    chk_all("press_e6", 4'hE, 4'h1, 4'h0, 1'b0);
    tick(1);
    chk_all("press_e7", 4'hE, 4'h1, 4'h1, 1'b1);
    wr(2'd3, 32'h1);
    chk_all("press_clr", 4'hE, 4'h1, 4'h0, 1'b0);
    in_port = 4'hF;
    tick(8);
    chk_all("release", 4'hF, 4'h1, 4'h0, 1'b0);

    // 3-cycle glitch on bit 1 must be invisible
    for (int i = 0; i < 14; i++) begin
      if (i == 0) in_port = 4'hD;
      if (i == 3) in_port = 4'hF;
      chk_all($sformatf("glitch%0d", i), 4'hF, 4'h1, 4'h0, 1'b0);
      tick(1);
    end

    // Capture while masked, then unmask
    wr(2'd1, 32'h0);
    in_port = 4'hB;
    tick(8);
    chk_all("mask_cap", 4'hB, 4'h0, 4'h4, 1'b0);
    wr(2'd1, 32'h4);
    chk_irq("mask_on", 1'b1);
    wr(2'd3, 32'h1);
    chk_rd("clr_other", 2'd3, 4'h4);
    wr(2'd3, 32'h4);
    chk_all("mask_clr", 4'hB, 4'h4, 4'h0, 1'b0);
    in_port = 4'hF;
    tick(8);
    chk_all("mask_rel", 4'hF, 4'h4, 4'h0, 1'b0);

    // Write-clear on the same edge that sets bit 3
    in_port = 4'h7;
    tick(6);
    chk_rd("col_pre", 2'd3, 4'h0);
    wr(2'd3, 32'h8);
    chk_all("col", 4'h7, 4'h4, 4'h8, 1'b0);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd2, 32'hFFFF_FFFF);
    chk_all("col_nowr", 4'h7, 4'h4, 4'h8, 1'b0);
    chk_rd("col_a2", 2'd2, 4'h0);
    wr(2'd1, 32'hF);
    chk_irq("col_irq", 1'b1);
    in_port = 4'hF;
    tick(8);
    chk_all("col_rel", 4'hF, 4'hF, 4'h8, 1'b1);

    // Reset two cycles into a debounce of bit 0
    in_port = 4'hE;
    tick(4);
    chk_rd("mid_pre", 2'd0, 4'hF);
    reset = 1'b1;
    tick(2);
    chk_all("mid_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    reset = 1'b0;
    tick(5);
    chk_rd("mid_e5", 2'd0, 4'h0);
    tick(1);
    chk_rd("mid_e6", 2'd0, 4'hE);
    tick(4);
    chk_all("mid_after", 4'hE, 4'h0, 4'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
